// File: rtl/pe_row_feeder_if.sv
// Host-side streams of the PE row feeder: a weight stream and an activation vector stream,
// both using valid/ready handshakes.
interface pe_row_feeder_if #(
  parameter int N_PE   = 4,
  parameter int DATA_W = 8
);
  logic                     w_valid;
  logic [DATA_W-1:0]        w_data;
  logic                     w_ready;
  logic                     a_valid;
  logic [N_PE*DATA_W-1:0]   a_data;
  logic                     a_last;
  logic                     a_ready;

  modport master (
    output w_valid, w_data, a_valid, a_data, a_last,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data, a_last,
    output w_ready, a_ready
  );
endinterface

// File: rtl/pe_row_feeder.sv
// Front end of the systolic PE chain: shifts one weight per PE into the chain, then streams
// activation vectors with a diagonal skew (lane k delayed k cycles).
module pe_row_feeder #(
  parameter int N_PE   = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  pe_row_feeder_if.slave         host,
  output logic                   pe_wen,
  output logic [DATA_W-1:0]      pe_win,
  output logic [N_PE*DATA_W-1:0] pe_ain,
  output logic [N_PE-1:0]        pe_avalid,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, FLUSH} state_t;

  localparam int              CW        = $clog2(N_PE + 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(N_PE);
  localparam logic [CW-1:0]   FLUSH_END = (N_PE > 1) ? CW'(N_PE - 2) : '0;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          w_loaded, w_loaded_n;
  logic          w_acc, a_acc;

  // Readiness depends only on state and w_valid so a weight always wins over a vector in IDLE.
  assign host.w_ready = (state == IDLE) || (state == LOAD_W);
  assign host.a_ready = (state == STREAM) || ((state == IDLE) && w_loaded && !host.w_valid);
  assign w_acc        = host.w_valid && host.w_ready;
  assign a_acc        = host.a_valid && host.a_ready;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    w_loaded_n = w_loaded;
    case (state)
      IDLE: begin
        if (w_acc) begin
          cnt_n = CW'(1);
          if (N_PE == 1) begin
            w_loaded_n = 1'b1;
            state_n    = STREAM;
          end else begin
            w_loaded_n = 1'b0;
            state_n    = LOAD_W;
          end
        end else if (a_acc) begin
          cnt_n = '0;
          if (host.a_last) state_n = (N_PE == 1) ? IDLE : FLUSH;
          else             state_n = STREAM;
        end
      end
      LOAD_W: begin
        if (w_acc) begin
          cnt_n = cnt + CW'(1);
          if (cnt + CW'(1) == CNT_FULL) begin
            w_loaded_n = 1'b1;
            state_n    = STREAM;
          end
        end
      end
      STREAM: begin
        if (a_acc && host.a_last) begin
          cnt_n   = '0;
          state_n = (N_PE == 1) ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_END) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      w_loaded <= 1'b0;
      pe_wen   <= 1'b0;
      pe_win   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      w_loaded <= w_loaded_n;
      pe_wen   <= w_acc;
      pe_win   <= w_acc ? host.w_data : '0;
      busy     <= (state_n != IDLE);
    end
  end

  // Lane k is a (k+1)-deep register line; a cycle without an accept shifts in a zero bubble.
  for (genvar k = 0; k < N_PE; k++) begin : g_lane
    logic [DATA_W-1:0] d_q [0:k];
    logic              v_q [0:k];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j <= k; j++) begin
          d_q[j] <= '0;
          v_q[j] <= 1'b0;
        end
      end else begin
        d_q[0] <= a_acc ? host.a_data[k*DATA_W +: DATA_W] : '0;
        v_q[0] <= a_acc;
        for (int j = 1; j <= k; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign pe_ain[k*DATA_W +: DATA_W] = d_q[k];
    assign pe_avalid[k]               = v_q[k];
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder: weight load, skew, bubbles, gating before weights,
// weight-over-vector priority and reset in the middle of a stream.
module tb_pe_row_feeder;

  logic        clk;
  logic        reset;
  logic        pe_wen;
  logic [7:0]  pe_win;
  logic [31:0] pe_ain;
  logic [3:0]  pe_avalid;
  logic        busy;
  int          checks;
  int          errors;

  pe_row_feeder_if #(.N_PE(4), .DATA_W(8)) host ();

  pe_row_feeder #(.N_PE(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (host),
    .pe_wen    (pe_wen),
    .pe_win    (pe_win),
    .pe_ain    (pe_ain),
    .pe_avalid (pe_avalid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic av,
                               input logic [31:0] ad, input logic al);
    host.w_valid = wv;
    host.w_data  = wd;
    host.a_valid = av;
    host.a_data  = ad;
    host.a_last  = al;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPe(input string tag, input logic [31:0] ain, input logic [3:0] av, input logic bsy);
    checkOutput({tag, ".ain"}, pe_ain, ain);
    checkOutput({tag, ".avalid"}, {28'd0, pe_avalid}, {28'd0, av});
    checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with an activation already waiting
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    checkPe("reset", 32'h0, 4'b0000, 1'b0);
    checkOutput("reset.wen", {31'd0, pe_wen}, 32'd0);
    checkOutput("reset.win", {24'd0, pe_win}, 32'd0);
    checkOutput("reset.w_ready", {31'd0, host.w_ready}, 32'd1);
    checkOutput("reset.a_ready", {31'd0, host.a_ready}, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("noweights.a_ready", {31'd0, host.a_ready}, 32'd0);
    checkPe("noweights", 32'h0, 4'b0000, 1'b0);

    // Weight load 1,2,3,4 with a_valid still held high
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 32'hDEADBEEF, 1'b0);
      checkOutput("load.a_ready", {31'd0, host.a_ready}, 32'd0);
      checkOutput("load.w_ready", {31'd0, host.w_ready}, 32'd1);
      tick();
      checkOutput("load.wen", {31'd0, pe_wen}, 32'd1);
      checkOutput("load.win", {24'd0, pe_win}, i);
      checkPe("load", 32'h0, 4'b0000, 1'b1);
    end

    // Skew: single last vector, lanes 9,8,7,6
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h06070809, 1'b1);
    checkOutput("stream.w_ready", {31'd0, host.w_ready}, 32'd0);
    checkOutput("stream.a_ready", {31'd0, host.a_ready}, 32'd1);
    tick();
    checkPe("skew1", 32'h00000009, 4'b0001, 1'b1);
    checkOutput("skew1.wen", {31'd0, pe_wen}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    checkOutput("flush.a_ready", {31'd0, host.a_ready}, 32'd0);
    checkOutput("flush.w_ready", {31'd0, host.w_ready}, 32'd0);
    tick();
    checkPe("skew2", 32'h00000800, 4'b0010, 1'b1);
    tick();
    checkPe("skew3", 32'h00070000, 4'b0100, 1'b1);
    tick();
    checkPe("skew4", 32'h06000000, 4'b1000, 1'b0);
    checkOutput("idle.w_ready", {31'd0, host.w_ready}, 32'd1);
    checkOutput("idle.a_ready", {31'd0, host.a_ready}, 32'd1);

    // Bubbles: A, gap, B(last) from IDLE reusing resident weights
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h44332211, 1'b0);
    tick();
    checkPe("bub1", 32'h00000011, 4'b0001, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    checkOutput("bub.a_ready", {31'd0, host.a_ready}, 32'd1);
    tick();
    checkPe("bub2", 32'h00002200, 4'b0010, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h80C3B2A1, 1'b1);
    tick();
    checkPe("bub3", 32'h003300A1, 4'b0101, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    tick();
    checkPe("bub4", 32'h4400B200, 4'b1010, 1'b1);
    tick();
    checkPe("bub5", 32'h00C30000, 4'b0100, 1'b1);
    tick();
    checkPe("bub6", 32'h80000000, 4'b1000, 1'b0);

    // Priority: weight and vector together in IDLE with weights loaded
    applyStimulus(1'b1, 8'h55, 1'b1, 32'hFFFFFFFF, 1'b1);
    checkOutput("prio.a_ready", {31'd0, host.a_ready}, 32'd0);
    checkOutput("prio.w_ready", {31'd0, host.w_ready}, 32'd1);
    tick();
    checkOutput("prio.wen", {31'd0, pe_wen}, 32'd1);
    checkOutput("prio.win", {24'd0, pe_win}, 32'h55);
    checkPe("prio", 32'h0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 32'hFFFFFFFF, 1'b1);
    checkOutput("prio.cleared.a_ready", {31'd0, host.a_ready}, 32'd0);
    tick();
    checkOutput("prio.idle.wen", {31'd0, pe_wen}, 32'd0);
    checkPe("prio.idle", 32'h0, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h66 + 8'(i) * 8'h11), 1'b1, 32'hFFFFFFFF, 1'b1);
      tick();
      checkOutput("prio.reload.win", {24'd0, pe_win}, 32'h66 + i * 32'h11);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    checkOutput("prio.stream.a_ready", {31'd0, host.a_ready}, 32'd1);

    // Reset with vectors in the skew lines
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h04030201, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h08070605, 1'b0);
    tick();
    checkPe("prereset", 32'h00000205, 4'b0011, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    tick();
    checkPe("midreset", 32'h0, 4'b0000, 1'b0);
    checkOutput("midreset.wen", {31'd0, pe_wen}, 32'd0);
    checkOutput("midreset.win", {24'd0, pe_win}, 32'd0);
    checkOutput("midreset.w_ready", {31'd0, host.w_ready}, 32'd1);
    checkOutput("midreset.a_ready", {31'd0, host.a_ready}, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h12345678, 1'b1);
    tick();
    checkOutput("postreset.a_ready", {31'd0, host.a_ready}, 32'd0);
    checkPe("postreset", 32'h0, 4'b0000, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 8'(i * 17), 1'b1, 32'h12345678, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h12345678, 1'b1);
    checkOutput("partial.a_ready", {31'd0, host.a_ready}, 32'd0);
    tick();
    checkPe("partial", 32'h0, 4'b0000, 1'b1);
    applyStimulus(1'b1, 8'h44, 1'b1, 32'h7F80FF01, 1'b1);
    tick();
    checkOutput("full.win", {24'd0, pe_win}, 32'h44);
    checkOutput("full.a_ready", {31'd0, host.a_ready}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 32'h7F80FF01, 1'b1);
    tick();
    checkPe("final1", 32'h00000001, 4'b0001, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    tick();
    checkPe("final2", 32'h0000FF00, 4'b0010, 1'b1);
    tick();
    checkPe("final3", 32'h00800000, 4'b0100, 1'b1);
    tick();
    checkPe("final4", 32'h7F000000, 4'b1000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_row_feeder.md
# pe_row_feeder

Front-end stage of the systolic PE chain. It loads one weight per PE by shifting weights down the `win`→`wout` chain under `wen`. It then streams activation vectors into the per-PE `ain` inputs with the diagonal skew the array needs: lane k is delayed k cycles. It sits directly between the host/buffer side (valid/ready streams) and the PE column.

## Interface
- `N_PE`, 4: number of PEs in the chain; width of the skew.
- `DATA_W`, 8: width of weights and activations (two's complement, passed through unmodified).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `w_valid`  in  1  weight word valid.
- `w_data`  in  DATA_W  weight word.
- `w_ready`  out  1  weight accepted when `w_valid && w_ready`.
- `a_valid`  in  1  activation vector valid.
- `a_data`  in  N_PE*DATA_W  lane k = bits [k*DATA_W +: DATA_W]; lane k feeds PE k (PE 0 = head of chain).
- `a_last`  in  1  marks the final vector of a batch; sampled on accept.
- `a_ready`  out  1  vector accepted when `a_valid && a_ready`.
- `pe_wen`  out  1  weight shift enable to the PE chain.
- `pe_win`  out  DATA_W  weight into PE 0.
- `pe_ain`  out  N_PE*DATA_W  skewed activations, lane k to PE k.
- `pe_avalid`  out  N_PE  per-lane activation valid.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD_W, STREAM, FLUSH. Internal `w_loaded` flag and a weight counter (0..N_PE) complete the state.
- IDLE:
  - `w_ready`=1.
  - `a_ready`=`w_loaded && !w_valid`. If both streams are valid in the same cycle, the weight wins.
  - A weight accept clears `w_loaded`, sets the count to 1, and goes to LOAD_W. If N_PE=1, it goes straight to STREAM with `w_loaded` set.
  - A vector accept behaves as in STREAM and reuses the resident weights.
- LOAD_W:
  - `w_ready`=1, `a_ready`=0.
  - Each accept increments the count. The accept that makes count==N_PE sets `w_loaded` and moves to STREAM.
  - Weight order: the first accepted weight ends in PE N_PE-1 and the last in PE 0.
- STREAM:
  - `w_ready`=0, `a_ready`=1.
  - An accept loads lane k into a skew line of depth k.
  - A cycle with no accept inserts a bubble: data 0, valid 0.
  - An accept with `a_last`=1 moves to FLUSH.
- FLUSH:
  - `a_ready`=0, `w_ready`=0.
  - Bubbles are inserted for N_PE-1 cycles so the skew drains, then the block returns to IDLE.
  - If N_PE=1, it returns to IDLE immediately.
- `pe_ain` lane is 0 whenever its `pe_avalid` bit is 0.
- No arithmetic is performed. Data is bit-exact; -128 in gives -128 out.
- Reset, including mid-load or mid-stream, has the following effects:
  - state goes to IDLE;
  - `w_loaded` and the counters are cleared;
  - all skew registers are cleared;
  - all outputs go to 0, including `busy`, `pe_wen`, `pe_win`, `pe_ain` and `pe_avalid`;
  - `w_ready`=1 and `a_ready`=0 from the first post-reset cycle.
- A partially loaded weight set is never marked loaded.

## Timing
- All `pe_*` outputs and `busy` are registered. `w_ready`/`a_ready` are combinational from state and `w_valid` only; they never depend on `a_valid`.
- Weight accepted at edge t: `pe_wen`=1 and `pe_win`=that weight during cycle t+1. `pe_wen`=0 in every cycle not following an accept.
- Vector accepted at edge t: lane k appears on `pe_ain[k]` with `pe_avalid[k]`=1 during cycle t+1+k, for exactly one cycle.
- Back-to-back accepts produce a continuous diagonal wavefront, one new vector per cycle.
- Last vector accepted at edge t: `busy` falls and `a_ready`/`w_ready` reflect IDLE in cycle t+N_PE. At that point the last lane has been presented in cycle t+N_PE.
- Sustained throughput is 1 weight/cycle in load and 1 vector/cycle in stream.

## Test plan
- Weight load: after reset, present weights 1,2,3,4 on consecutive cycles. Required: `pe_wen`=1 for 4 cycles with `pe_win`=1,2,3,4; `busy`=1; the FSM enters STREAM; `a_ready`=1.
- Skew: accept vector {lane0=9,lane1=8,lane2=7,lane3=6} with `a_last`=1 at edge t. Required: `pe_ain`[0..3]=9,8,7,6 in cycles t+1, t+2, t+3, t+4 respectively, each with only its valid bit set; the block is back in IDLE at t+4.
- Bubbles: accept vector A, leave `a_valid`=0 for one cycle, then accept B with `a_last`=1. Required: each lane shows A, then a zero with valid=0, then B; there is no merge or duplication.
- Activation before weights: drive `a_valid`=1 immediately after reset. Required: `a_ready`=0 until 4 weights are accepted, and no `pe_avalid` bit is asserted.
- Priority in IDLE with `w_loaded`=1: drive `w_valid` and `a_valid` together. Required: the weight is accepted, `a_ready`=0, the FSM moves to LOAD_W, and `w_loaded` is cleared.
- Reset mid-stream: assert `reset` for 1 cycle while vectors are in the skew lines. Required: all `pe_*` outputs and `busy` are 0 the next cycle; `a_ready`=0 until a full reload of 4 weights.
